// File: rtl/ls_ctrl_fsm_pkg.sv
// Shared constants for the lw/sw load-store controller: opcodes, ALU code and state encoding.
package ls_ctrl_fsm_pkg;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_NOP = 4'b0000;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DECODE  = 3'd1;
    localparam logic [2:0] ADDR    = 3'd2;
    localparam logic [2:0] MEM     = 3'd3;
    localparam logic [2:0] WB      = 3'd4;

    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/ls_ctrl_fsm_mem_wait_counter.sv
// Down-counter that holds the controller in MEM for a configurable number of cycles.
module ls_ctrl_fsm_mem_wait_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ls_ctrl_fsm.sv
// Multi-cycle lw/sw controller: accepts one instruction per handshake and
// sequences DECODE->ADDR->MEM->WB, driving the datapath control strobes.
module ls_ctrl_fsm
    import ls_ctrl_fsm_pkg::*;
#(
    parameter int N       = 32,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    input  logic [N-1:0] instruction,
    output logic         instr_ready,
    output logic [N-1:0] ir_out,
    output logic [3:0]   ALU_OP,
    output logic         RegWrite,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         done,
    output logic         illegal
);

    localparam int             CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(MEM_LAT - 1);

    logic [2:0]   r_state;
    logic [N-1:0] r_ir;
    logic         r_done;
    logic         r_illegal;

    logic         w_is_lw;
    logic         w_is_sw;
    logic         w_cnt_load;
    logic         w_cnt_dec;
    logic         w_cnt_zero;

    assign w_is_lw    = (r_ir[31:26] == OP_LW);
    assign w_is_sw    = (r_ir[31:26] == OP_SW);
    assign w_cnt_load = (r_state == ADDR);
    assign w_cnt_dec  = (r_state == MEM) && !w_cnt_zero;

    ls_ctrl_fsm_mem_wait_counter #(
        .W (CW)
    ) u_mem_wait (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // done/illegal are one-cycle pulses raised on the edge that re-enters IDLE,
    // so they coincide with instr_ready and allow a back-to-back accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_ir    <= instruction;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_mem_op(r_ir[31:26])) begin
                        r_state <= ADDR;
                    end else begin
                        r_state   <= IDLE;
                        r_illegal <= 1'b1;
                    end
                end
                ADDR: r_state <= MEM;
                MEM: begin
                    if (w_cnt_zero) begin
                        if (w_is_lw) begin
                            r_state <= WB;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                WB: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: every output of this always_comb gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        ALU_OP   = ALU_NOP;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        case (r_state)
            ADDR: ALU_OP = ALU_ADD;
            MEM: begin
                ALU_OP   = ALU_ADD;
                MemRead  = w_is_lw;
                MemWrite = w_is_sw;
            end
            WB: begin
                ALU_OP   = ALU_ADD;
                RegWrite = 1'b1;
                MemRead  = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_ready = (r_state == IDLE) && !rst;
    assign ir_out      = r_ir;
    assign done        = r_done;
    assign illegal     = r_illegal;

endmodule
